// File: rtl/board_writer_pkg.sv
// Shared types and constants for the board-state writer and its update FIFO.
package board_writer_pkg;

  localparam int BOARD_AW = 10;
  localparam int BOARD_DW = 16;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    CLEAR
  } board_wr_state_t;

  // One queued update: RAM word address plus the new board-state word.
  typedef struct packed {
    logic [BOARD_AW-1:0] addr;
    logic [BOARD_DW-1:0] data;
  } board_upd_t;

endpackage

// File: rtl/board_writer_sync_fifo.sv
// Single-clock FIFO with synchronous flush; DEPTH must be a power of two.
module sync_fifo
  import board_writer_pkg::*;
#(
  parameter int WIDTH = $bits(board_upd_t),
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign level    = count;
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is not reset; the pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/board_writer.sv
// Board-state RAM writer: queues game updates and sweeps zero-fill clears.
// Define BOARD_WRITER_TEAR_GUARD_EN to restrict RAM writes to vertical blanking.
module board_writer
  import board_writer_pkg::*;
#(
  parameter int NUM_WORDS  = 1024,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vblank,
  input  logic        upd_valid,
  input  logic [9:0]  upd_addr,
  input  logic [15:0] upd_data,
  output logic        upd_ready,
  input  logic        clear_req,
  output logic        we,
  output logic [9:0]  waddr,
  output logic [15:0] wdata,
  output logic        busy,
  output logic [5:0]  level
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BOARD_AW-1:0] LAST_ADDR = BOARD_AW'(NUM_WORDS - 1);

  board_wr_state_t     state;
  board_wr_state_t     state_nxt;
  board_upd_t          push_ent;
  board_upd_t          pop_ent;
  logic                wr_ok;
  logic                clear_pending;
  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_push;
  logic                fifo_pop;
  logic                fifo_flush;
  logic                fifo_last;
  logic [LW-1:0]       fifo_level;
  logic                clr_wr;
  logic [BOARD_AW-1:0] clr_cnt;

`ifdef BOARD_WRITER_TEAR_GUARD_EN
  assign wr_ok = vblank;
`else
  logic unused_vblank;
  assign unused_vblank = vblank;
  assign wr_ok         = 1'b1;
`endif

  assign push_ent  = {upd_addr, upd_data};
  assign fifo_push = upd_valid && upd_ready;
  // The pop that empties the FIFO, with no refill arriving in the same cycle.
  assign fifo_last = fifo_pop && !fifo_push && (fifo_level == LW'(1));
  assign busy      = (state == CLEAR) || !fifo_empty;
  assign level     = 6'(fifo_level);

  sync_fifo #(
    .WIDTH ($bits(board_upd_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (push_ent),
    .pop       (fifo_pop),
    .flush     (fifo_flush),
    .pop_data  (pop_ent),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (clear_pending)                 state_nxt = CLEAR;
        else if (!fifo_empty && !fifo_last) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (clear_pending)                 state_nxt = CLEAR;
        else if (fifo_last || fifo_empty)  state_nxt = IDLE;
      end
      CLEAR: begin
        if (!clear_req && clr_wr && (clr_cnt == LAST_ADDR)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    upd_ready  = 1'b0;
    fifo_pop   = 1'b0;
    fifo_flush = 1'b0;
    clr_wr     = 1'b0;
    unique case (state)
      IDLE, DRAIN: begin
        upd_ready  = !fifo_full && !clear_pending && !reset;
        fifo_flush = clear_pending;
        fifo_pop   = !clear_pending && !fifo_empty && wr_ok;
      end
      CLEAR:   clr_wr = wr_ok;
      default: ;
    endcase
  end

  // Write port registers, clear sweep counter and the pending-clear flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      we            <= 1'b0;
      waddr         <= '0;
      wdata         <= '0;
      clr_cnt       <= '0;
      clear_pending <= 1'b0;
    end else begin
      we <= fifo_pop || clr_wr;
      if (fifo_pop) begin
        waddr <= pop_ent.addr;
        wdata <= pop_ent.data;
      end else if (clr_wr) begin
        waddr <= clr_cnt;
        wdata <= '0;
      end

      if (state == CLEAR) begin
        if (clear_req)                               clr_cnt <= '0;
        else if (clr_wr && (clr_cnt == LAST_ADDR))   clr_cnt <= '0;
        else if (clr_wr)                             clr_cnt <= clr_cnt + BOARD_AW'(1);
      end else if (clear_pending) begin
        clr_cnt <= '0;
      end

      // A request seen outside CLEAR is acted on exactly once, in the following cycle.
      clear_pending <= (state != CLEAR) && !clear_pending && clear_req;
    end
  end

endmodule

// File: tb/tb_board_writer.sv
// Self-checking bench for board_writer; expected RAM writes flow through a scoreboard queue.
module tb_board_writer;

  localparam int NUM_WORDS  = 600;
  localparam int FIFO_DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        vblank;
  logic        upd_valid;
  logic [9:0]  upd_addr;
  logic [15:0] upd_data;
  logic        upd_ready;
  logic        clear_req;
  logic        we;
  logic [9:0]  waddr;
  logic [15:0] wdata;
  logic        busy;
  logic [5:0]  level;

  int checks      = 0;
  int failures    = 0;
  int cyc         = 0;
  int wr_count    = 0;
  int last_wr_cyc = -10;
  int run_len     = 0;
  bit sb_on       = 1'b1;

  logic [25:0] exp_q [$];
  logic [9:0]  log_q [$];
  logic [25:0] exp_w;

  logic [9:0]  b2b_addr [6] = '{10'h100, 10'h100, 10'h3FF, 10'h000, 10'h100, 10'h155};
  logic [15:0] b2b_data [6] = '{16'h1111, 16'h2222, 16'hFFFF, 16'h0001, 16'h3333, 16'hAAAA};

  board_writer #(
    .NUM_WORDS  (NUM_WORDS),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .vblank    (vblank),
    .upd_valid (upd_valid),
    .upd_addr  (upd_addr),
    .upd_data  (upd_data),
    .upd_ready (upd_ready),
    .clear_req (clear_req),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .busy      (busy),
    .level     (level)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Write monitor: every observed RAM write is either scored or logged.
  always @(negedge clk) begin
    if (we === 1'b1 && reset === 1'b0) begin
      if (last_wr_cyc == cyc - 1) run_len++;
      else                        run_len = 1;
      last_wr_cyc = cyc;
      wr_count++;
      if (sb_on) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_write: got addr=%h data=%h, required no write", waddr, wdata);
        end else begin
          exp_w = exp_q.pop_front();
          if ({waddr, wdata} !== exp_w) begin
            failures++;
            $display("FAIL write_order: got addr=%h data=%h, required addr=%h data=%h",
                     waddr, wdata, exp_w[25:16], exp_w[15:0]);
          end
        end
      end else begin
        log_q.push_back(waddr);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    upd_valid = 1'b0;
    clear_req = 1'b0;
    upd_addr  = '0;
    upd_data  = '0;
  endtask

  task automatic wait_writes(input int target, input int budget, input string name);
    int n = 0;
    while (wr_count < target && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (wr_count < target) begin
      failures++;
      $display("FAIL %s_timeout: got %0d writes, required %0d", name, wr_count, target);
    end
  endtask

  task automatic queue_clear_sweep();
    for (int i = 0; i < NUM_WORDS; i++) exp_q.push_back({10'(i), 16'h0000});
  endtask

  task automatic test_reset();
    reset = 1'b1;
    vblank = 1'b1;
    idle_inputs();
    repeat (3) tick();
    checks++;
    if (upd_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready: got %b, required 0", upd_ready);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (we !== 1'b0)      begin failures++; $display("FAIL reset_we: got %b, required 0", we); end
    checks++;
    if (waddr !== 10'h0)  begin failures++; $display("FAIL reset_waddr: got %h, required 000", waddr); end
    checks++;
    if (wdata !== 16'h0)  begin failures++; $display("FAIL reset_wdata: got %h, required 0000", wdata); end
    checks++;
    if (busy !== 1'b0)    begin failures++; $display("FAIL reset_busy: got %b, required 0", busy); end
    checks++;
    if (level !== 6'd0)   begin failures++; $display("FAIL reset_level: got %0d, required 0", level); end
    checks++;
    if (upd_ready !== 1'b1) begin failures++; $display("FAIL reset_ready_after: got %b, required 1", upd_ready); end
  endtask

  task automatic test_single();
    int acc;
    int base;
    base = wr_count;
    exp_q.push_back({10'h015, 16'hA5A5});
    upd_valid = 1'b1;
    upd_addr  = 10'h015;
    upd_data  = 16'hA5A5;
    checks++;
    if (upd_ready !== 1'b1) begin failures++; $display("FAIL single_ready: got %b, required 1", upd_ready); end
    acc = cyc;
    tick();
    idle_inputs();
    wait_writes(base + 1, 10, "single");
    checks++;
    if (last_wr_cyc !== acc + 2) begin
      failures++;
      $display("FAIL single_latency: got cycle %0d, required %0d", last_wr_cyc, acc + 2);
    end
    tick();
    checks++;
    if (we !== 1'b0)   begin failures++; $display("FAIL single_we_idle: got %b, required 0", we); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL single_busy: got %b, required 0", busy); end
  endtask

  task automatic test_back_to_back();
    int base;
    base = wr_count;
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back({b2b_addr[i], b2b_data[i]});
      upd_valid = 1'b1;
      upd_addr  = b2b_addr[i];
      upd_data  = b2b_data[i];
      checks++;
      if (upd_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_%0d: got %b, required 1", i, upd_ready); end
      tick();
    end
    idle_inputs();
    wait_writes(base + 6, 20, "b2b");
    checks++;
    if (run_len !== 6) begin failures++; $display("FAIL b2b_consecutive: got run %0d, required 6", run_len); end
    repeat (2) tick();
    checks++;
    if (busy !== 1'b0 || level !== 6'd0) begin
      failures++;
      $display("FAIL b2b_drained: got busy=%b level=%0d, required busy=0 level=0", busy, level);
    end
  endtask

  task automatic test_clear();
    int base;
    int n;
    bit ready_bad;
    base = wr_count;
    queue_clear_sweep();
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    ready_bad = 1'b0;
    n = 0;
    while (wr_count < base + NUM_WORDS && n < 2000) begin
      if (upd_ready !== 1'b0) ready_bad = 1'b1;
      tick();
      n++;
    end
    checks++;
    if (wr_count < base + NUM_WORDS) begin
      failures++;
      $display("FAIL clear_timeout: got %0d writes, required %0d", wr_count - base, NUM_WORDS);
    end
    checks++;
    if (ready_bad) begin failures++; $display("FAIL clear_ready: got upd_ready=1 during clear, required 0"); end
    checks++;
    if (run_len !== NUM_WORDS) begin
      failures++;
      $display("FAIL clear_consecutive: got run %0d, required %0d", run_len, NUM_WORDS);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || upd_ready !== 1'b1 || we !== 1'b0) begin
      failures++;
      $display("FAIL clear_done: got busy=%b ready=%b we=%b, required 0 1 0", busy, upd_ready, we);
    end
  endtask

  task automatic test_clear_flush();
    int base;
    base = wr_count;
`ifdef BOARD_WRITER_TEAR_GUARD_EN
    vblank = 1'b0;
    for (int i = 0; i < 3; i++) begin
      upd_valid = 1'b1;
      upd_addr  = 10'h3F0 + 10'(i);
      upd_data  = 16'hDEAD;
      tick();
    end
    idle_inputs();
    checks++;
    if (level !== 6'd3) begin failures++; $display("FAIL flush_queued: got level %0d, required 3", level); end
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
`else
    upd_valid = 1'b1;
    upd_addr  = 10'h3FF;
    upd_data  = 16'hDEAD;
    clear_req = 1'b1;
    tick();
    idle_inputs();
`endif
    queue_clear_sweep();
    tick();
    checks++;
    if (level !== 6'd0) begin failures++; $display("FAIL flush_level: got %0d, required 0", level); end
    vblank = 1'b1;
    wait_writes(base + NUM_WORDS, 2000, "flush");
    repeat (5) tick();
    checks++;
    if (exp_q.size() !== 0 || wr_count !== base + NUM_WORDS) begin
      failures++;
      $display("FAIL flush_count: got %0d writes, required %0d", wr_count - base, NUM_WORDS);
    end
  endtask

  task automatic test_clear_restart();
    int n;
    int k;
    bit seq_ok;
    sb_on = 1'b0;
    log_q.delete();
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (25) tick();
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL restart_timeout: got busy=%b, required 0", busy); end
    tick();
    k = -1;
    for (int i = 1; i < log_q.size(); i++) if (log_q[i] == 10'h0 && k < 0) k = i;
    checks++;
    if (k <= 0) begin
      failures++;
      $display("FAIL restart_seen: got no restart in %0d writes, required one", log_q.size());
    end else begin
      seq_ok = 1'b1;
      for (int i = 0; i < k; i++) if (log_q[i] != 10'(i)) seq_ok = 1'b0;
      checks++;
      if (!seq_ok) begin failures++; $display("FAIL restart_first: got gap in first sweep, required 0..%0d", k - 1); end
      checks++;
      if (log_q.size() - k !== NUM_WORDS) begin
        failures++;
        $display("FAIL restart_len: got %0d writes, required %0d", log_q.size() - k, NUM_WORDS);
      end
      seq_ok = 1'b1;
      for (int i = k; i < log_q.size(); i++) if (log_q[i] != 10'(i - k)) seq_ok = 1'b0;
      checks++;
      if (!seq_ok) begin failures++; $display("FAIL restart_second: got out-of-order sweep, required 0..%0d", NUM_WORDS - 1); end
    end
    sb_on = 1'b1;
  endtask

  task automatic test_reset_mid_clear();
    int base;
    sb_on = 1'b0;
    base = wr_count;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    wait_writes(base + 50, 200, "midclear");
    reset = 1'b1;
    tick();
    checks++;
    if (upd_ready !== 1'b0) begin failures++; $display("FAIL midclear_ready_rst: got %b, required 0", upd_ready); end
    reset = 1'b0;
    checks++;
    if (we !== 1'b0)     begin failures++; $display("FAIL midclear_we: got %b, required 0", we); end
    checks++;
    if (level !== 6'd0)  begin failures++; $display("FAIL midclear_level: got %0d, required 0", level); end
    sb_on = 1'b1;
    base = wr_count;
    repeat (30) tick();
    checks++;
    if (wr_count !== base || busy !== 1'b0) begin
      failures++;
      $display("FAIL midclear_quiet: got %0d writes busy=%b, required 0 writes busy=0", wr_count - base, busy);
    end
    checks++;
    if (upd_ready !== 1'b1) begin failures++; $display("FAIL midclear_ready: got %b, required 1", upd_ready); end
  endtask

`ifdef BOARD_WRITER_TEAR_GUARD_EN
  task automatic test_backpressure();
    int base;
    base = wr_count;
    vblank = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      exp_q.push_back({10'h200 + 10'(i), 16'hC000 + 16'(i)});
      upd_valid = 1'b1;
      upd_addr  = 10'h200 + 10'(i);
      upd_data  = 16'hC000 + 16'(i);
      checks++;
      if (upd_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_%0d: got %b, required 1", i, upd_ready); end
      tick();
    end
    upd_addr = 10'h2FF;
    upd_data = 16'hBAD0;
    checks++;
    if (upd_ready !== 1'b0) begin failures++; $display("FAIL bp_full_ready: got %b, required 0", upd_ready); end
    checks++;
    if (level !== 6'(FIFO_DEPTH)) begin failures++; $display("FAIL bp_level: got %0d, required %0d", level, FIFO_DEPTH); end
    tick();
    idle_inputs();
    checks++;
    if (wr_count !== base) begin failures++; $display("FAIL bp_no_write: got %0d writes, required 0", wr_count - base); end
    vblank = 1'b1;
    wait_writes(base + FIFO_DEPTH, 30, "bp");
    checks++;
    if (run_len !== FIFO_DEPTH) begin failures++; $display("FAIL bp_consecutive: got run %0d, required %0d", run_len, FIFO_DEPTH); end
  endtask

  task automatic test_clear_pause();
    int base;
    base = wr_count;
    vblank = 1'b1;
    queue_clear_sweep();
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    wait_writes(base + 100, 300, "pause_pre");
    vblank = 1'b0;
    repeat (10) tick();
    checks++;
    if (wr_count !== base + 100) begin failures++; $display("FAIL pause_hold: got %0d writes, required 100", wr_count - base); end
    checks++;
    if (busy !== 1'b1 || we !== 1'b0) begin
      failures++;
      $display("FAIL pause_state: got busy=%b we=%b, required 1 0", busy, we);
    end
    vblank = 1'b1;
    wait_writes(base + NUM_WORDS, 2000, "pause_post");
    repeat (3) tick();
    checks++;
    if (exp_q.size() !== 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL pause_done: got %0d left busy=%b, required 0 0", exp_q.size(), busy);
    end
  endtask
`endif

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_clear();
    test_clear_flush();
    test_clear_restart();
    test_reset_mid_clear();
`ifdef BOARD_WRITER_TEAR_GUARD_EN
    test_backpressure();
    test_clear_pause();
`endif
    checks++;
    if (exp_q.size() !== 0) begin
      failures++;
      $display("FAIL scoreboard_left: got %0d pending, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
